sram_ctrl: RTL and testbench
============================

# sram_ctrl

- Multi-cycle access controller between the MEM stage and a 16-bit external asynchronous SRAM.
- Translates each 32-bit word read/write from the pipeline into two sequenced half-word SRAM accesses with programmable wait states.
- Drives `ready` low to freeze the pipeline until the word access completes.
- Replaces direct single-cycle data memory access in the MEM stage. Address map and big-endian byte ordering are unchanged.

## Interface
Parameters:
- `WAIT_CYCLES`, 2: clock cycles per half-word phase; legal range ≥2.
- `MEM_BASE`, 1024: data segment base; subtracted from `adr` when `adr >= MEM_BASE`.
- `SRAM_AW`, 18: SRAM half-word address width.

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: system clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wr_en` in 1: word write request from the MEM stage.
- `rd_en` in 1: word read request from the MEM stage.
- `adr` in 32: byte address; bits [1:0] are ignored.
- `wdata` in 32: write data.
- `rdata` out 32: read data; 0 unless `rd_en` is high and the controller is in DONE.
- `ready` out 1: 1 means the pipeline may advance; freeze = ~ready.
- `sram_addr` out SRAM_AW: half-word address.
- `sram_dq_out` out 16: write data to the SRAM.
- `sram_dq_in` in 16: read data from the SRAM.
- `sram_dq_oe` out 1: tristate enable for `sram_dq_out`.
- `sram_ce_n` out 1: chip enable, active low.
- `sram_we_n` out 1: write enable, active low.

## Operation
- **Address translation:**
  - `na = (adr >= MEM_BASE) ? adr - MEM_BASE : adr`.
  - word index `w = na[SRAM_AW:2]`.
  - HI half at `{w,1'b0}` holds bits [31:16]; LO half at `{w,1'b1}` holds bits [15:0] (big-endian).
- **FSM states:** IDLE, PH0, PH1, DONE. A phase counter counts 0..WAIT_CYCLES-1 inside PH0 and PH1.
- **IDLE:**
  - Request (`rd_en|wr_en`) → PH0, latching the op, `w` and `wdata`.
  - `ready = ~(rd_en|wr_en)`, combinational.
- **PH0:** accesses the HI half. After WAIT_CYCLES cycles → PH1.
- **PH1:** accesses the LO half. After WAIT_CYCLES cycles → DONE.
- **DONE:**
  - `ready=1` for exactly one cycle; `rdata` = assembled word when `rd_en`.
  - Unconditionally → IDLE. A request still present in DONE is not restarted.
- **Requests:** the pipeline holds `adr`, `wdata`, `rd_en` and `wr_en` stable while `ready=0`. Changes during PH0/PH1 are ignored, since latched values are used.
- **Simultaneous `rd_en` and `wr_en`:** treated as a write; `rdata` = 0.
- **SRAM signalling in PH0/PH1:**
  - `sram_ce_n=0`.
  - Write: `sram_dq_oe=1`, data stable the whole phase; `sram_we_n=0` on every phase cycle except the last, which gives a hold cycle.
  - Read: `sram_dq_oe=0`, `sram_we_n=1`; `sram_dq_in` is sampled on the last cycle of the phase.
- **IDLE/DONE SRAM outputs:** `sram_ce_n=1`, `sram_we_n=1`, `sram_dq_oe=0`, `sram_addr=0`.
- **Reset values** (immediate and asynchronous, including mid-phase):
  - State IDLE, counter 0, read word register 0.
  - `ready` = ~(rd_en|wr_en), `rdata=0`, `sram_ce_n=1`, `sram_we_n=1`, `sram_dq_oe=0`, `sram_addr=0`.
  - A half-written word is not completed or rolled back.

## Timing
- Request visible in cycle 0 (IDLE). PH0 occupies cycles 1..W, PH1 occupies W+1..2W, DONE is cycle 2W+1.
- `ready` is low for cycles 0..2W, i.e. 2W+1 cycles. W=2 gives 5 frozen cycles, then DONE.
- Back-to-back requests: IDLE is re-entered after DONE, so the next access begins with its own cycle 0.
- All SRAM outputs are registered except `ready` and `rdata` gating.

## Configuration
- `SRAM_CTRL_RDBUF_EN` defined: adds a one-entry read buffer holding the last read word index, its data and a valid bit.
  - A read in IDLE that hits a valid entry keeps `ready=1` and returns the buffered word combinationally, with no SRAM cycle.
  - Any write, or reset, clears the valid bit.
  - A completed read fills the buffer.
- Undefined: every read performs the full PH0/PH1 sequence.

## Structure
- Shared package `sram_ctrl_pkg`: state enum (IDLE, PH0, PH1, DONE), `MEM_BASE` constant, half-select constants.
- Sub-module `sram_rd_buf`: the read buffer, instantiated only under `SRAM_CTRL_RDBUF_EN`.
- FSM, counter and SRAM pin drive stay in `sram_ctrl`.

## Test plan
All scenarios use W=2.
1. Write 0xDEADBEEF to `adr` 1028 → `sram_addr` 2 receives 0xDEAD, `sram_addr` 3 receives 0xBEEF; `ready` low for 5 cycles, high in the 6th.
2. Read `adr` 1028 after scenario 1 → `rdata`=0xDEADBEEF in the DONE cycle; `rdata`=0 in all other cycles.
3. Read `adr` 8, below MEM_BASE → SRAM accesses at `sram_addr` 4 then 5.
4. Assert `rst` during PH1 of a write → same cycle: `sram_we_n=1`, `sram_ce_n=1`; the next request starts at PH0.
5. `rd_en=wr_en=1`, `adr` 1032, `wdata` 0x12345678 → write performed; `rdata`=0 throughout.
6. With `SRAM_CTRL_RDBUF_EN`, read 1028 twice:
   - Second read → `ready` stays 1, `sram_ce_n` stays 1.
   - Then write 1028 and read 1028 → full 5-cycle freeze.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared definitions for the MEM-stage SRAM access controller: FSM states,
// the default data segment base, half-word select bits and the address
// translation helper used to map pipeline byte addresses onto the SRAM.
package sram_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PH0,
        PH1,
        DONE
    } state_t;

    localparam int DEFAULT_MEM_BASE = 1024;

    // Big-endian: the even half-word holds bits [31:16], the odd one [15:0].
    localparam logic HALF_HI = 1'b0;
    localparam logic HALF_LO = 1'b1;

    function automatic logic [31:0] translate_adr(input logic [31:0] adr,
                                                  input logic [31:0] base);
        return (adr >= base) ? adr - base : adr;
    endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// Bundle of the MEM-stage request/response signals and the external SRAM
// pins. The slave side is the controller; the master side is its
// environment (pipeline plus SRAM device).
interface sram_ctrl_if #(
    parameter int SRAM_AW = 18
);
    logic               wr_en;
    logic               rd_en;
    logic [31:0]        adr;
    logic [31:0]        wdata;
    logic [31:0]        rdata;
    logic               ready;
    logic [SRAM_AW-1:0] sram_addr;
    logic [15:0]        sram_dq_out;
    logic [15:0]        sram_dq_in;
    logic               sram_dq_oe;
    logic               sram_ce_n;
    logic               sram_we_n;

    modport master (
        output wr_en, rd_en, adr, wdata, sram_dq_in,
        input  rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_we_n
    );

    modport slave (
        input  wr_en, rd_en, adr, wdata, sram_dq_in,
        output rdata, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_ce_n, sram_we_n
    );

endinterface

// File: rtl/sram_rd_buf.sv
// One-entry read buffer: remembers the word index and data of the last
// completed read so a repeated read can be answered without an SRAM cycle.
// Only instantiated when SRAM_CTRL_RDBUF_EN is defined.
module sram_rd_buf
    import sram_ctrl_pkg::*;
#(
    parameter int IW = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [IW-1:0] lookup_idx,
    output logic          hit,
    output logic [31:0]   hit_data,
    input  logic          fill,
    input  logic [IW-1:0] fill_idx,
    input  logic [31:0]   fill_data,
    input  logic          clear
);

    logic          valid_q;
    logic [IW-1:0] idx_q;
    logic [31:0]   data_q;

    // Writes invalidate the entry; a finished read replaces it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
        end else if (clear) begin
            valid_q <= 1'b0;
        end else if (fill) begin
            valid_q <= 1'b1;
            idx_q   <= fill_idx;
            data_q  <= fill_data;
        end
    end

    assign hit      = valid_q && (idx_q == lookup_idx);
    assign hit_data = data_q;

endmodule

// File: rtl/sram_ctrl.sv
// MEM-stage controller for a 16-bit asynchronous SRAM. Each 32-bit word
// access becomes two half-word phases (HI then LO) of WAIT_CYCLES clocks,
// with ready held low until the word is complete.
// Optional feature: define SRAM_CTRL_RDBUF_EN to add a one-entry read
// buffer that answers repeated reads of the same word without SRAM cycles.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int MEM_BASE    = DEFAULT_MEM_BASE,
    parameter int SRAM_AW     = 18
) (
    input  logic       clk,
    input  logic       rst,
    sram_ctrl_if.slave bus
);

    localparam int IW = SRAM_AW - 1;
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST    = CW'(WAIT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_PRELAST = CW'(WAIT_CYCLES - 2);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic               op_wr;
    logic [IW-1:0]      idx_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rd_word;
    logic [SRAM_AW-1:0] sram_addr_q;
    logic [15:0]        dq_out_q;
    logic               dq_oe_q;
    logic               ce_n_q;
    logic               we_n_q;

    logic [31:0]        na;
    logic [IW-1:0]      req_idx;
    logic               req;
    logic               rd_only;
    logic               start;
    logic               buf_hit;
    logic [31:0]        buf_data;
    logic               ready_c;
    logic [31:0]        rdata_c;
    logic               unused_na_bits;

    assign na             = translate_adr(bus.adr, 32'(MEM_BASE));
    assign req_idx        = na[SRAM_AW:2];
    assign unused_na_bits = ^{na[31:SRAM_AW+1], na[1:0]};
    assign req            = bus.rd_en | bus.wr_en;
    assign rd_only        = bus.rd_en & ~bus.wr_en;

`ifdef SRAM_CTRL_RDBUF_EN
    logic rb_hit;

    sram_rd_buf #(
        .IW (IW)
    ) u_rd_buf (
        .clk        (clk),
        .rst        (rst),
        .lookup_idx (req_idx),
        .hit        (rb_hit),
        .hit_data   (buf_data),
        .fill       ((state == DONE) && !op_wr),
        .fill_idx   (idx_q),
        .fill_data  (rd_word),
        .clear      ((state == IDLE) && bus.wr_en)
    );

    assign buf_hit = (state == IDLE) && rd_only && rb_hit;
`else
    assign buf_hit  = 1'b0;
    assign buf_data = '0;
`endif

    assign start = (state == IDLE) && req && !buf_hit;

    // Sequencer: walks IDLE -> PH0 -> PH1 -> DONE, latching the request on
    // entry and setting the SRAM pins one clock ahead so they are registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            op_wr       <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            rd_word     <= '0;
            sram_addr_q <= '0;
            dq_out_q    <= '0;
            dq_oe_q     <= 1'b0;
            ce_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state       <= PH0;
                        cnt         <= '0;
                        op_wr       <= bus.wr_en;
                        idx_q       <= req_idx;
                        wdata_q     <= bus.wdata;
                        sram_addr_q <= {req_idx, HALF_HI};
                        dq_out_q    <= bus.wdata[31:16];
                        dq_oe_q     <= bus.wr_en;
                        ce_n_q      <= 1'b0;
                        we_n_q      <= ~bus.wr_en;
                    end
                end
                PH0: begin
                    if (cnt == CNT_LAST) begin
                        state       <= PH1;
                        cnt         <= '0;
                        if (!op_wr) begin
                            rd_word[31:16] <= bus.sram_dq_in;
                        end
                        sram_addr_q <= {idx_q, HALF_LO};
                        dq_out_q    <= wdata_q[15:0];
                        we_n_q      <= ~op_wr;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_PRELAST) begin
                            we_n_q <= 1'b1;
                        end
                    end
                end
                PH1: begin
                    if (cnt == CNT_LAST) begin
                        state       <= DONE;
                        cnt         <= '0;
                        if (!op_wr) begin
                            rd_word[15:0] <= bus.sram_dq_in;
                        end
                        sram_addr_q <= '0;
                        dq_out_q    <= '0;
                        dq_oe_q     <= 1'b0;
                        ce_n_q      <= 1'b1;
                        we_n_q      <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_PRELAST) begin
                            we_n_q <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Pipeline-facing handshake: ready/rdata are the only unregistered outputs.
    always_comb begin
        ready_c = 1'b0;
        rdata_c = '0;
        case (state)
            IDLE: begin
                ready_c = ~req | buf_hit;
                if (buf_hit) begin
                    rdata_c = buf_data;
                end
            end
            DONE: begin
                ready_c = 1'b1;
                if (bus.rd_en && !op_wr) begin
                    rdata_c = rd_word;
                end
            end
            default: begin
                ready_c = 1'b0;
            end
        endcase
    end

    assign bus.ready       = ready_c;
    assign bus.rdata       = rdata_c;
    assign bus.sram_addr   = sram_addr_q;
    assign bus.sram_dq_out = dq_out_q;
    assign bus.sram_dq_oe  = dq_oe_q;
    assign bus.sram_ce_n   = ce_n_q;
    assign bus.sram_we_n   = we_n_q;

endmodule

// File: tb/tb_sram_ctrl.sv
// Self-checking bench for sram_ctrl: directed scenarios followed by random
// word reads/writes, compared against a word-level memory model.
module tb_sram_ctrl;

    localparam int W     = 2;
    localparam int AW    = 18;
    localparam int BASE  = 1024;
    localparam int NHALF = 1 << AW;

`ifdef SRAM_CTRL_RDBUF_EN
    localparam bit HAS_BUF = 1'b1;
`else
    localparam bit HAS_BUF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;

    sram_ctrl_if #(.SRAM_AW(AW)) bus ();

    sram_ctrl #(
        .WAIT_CYCLES (W),
        .MEM_BASE    (BASE),
        .SRAM_AW     (AW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:NHALF-1];
    logic [15:0] ref_half [int];
    int          checks = 0;
    int          errors = 0;
    bit          buf_valid = 1'b0;
    int          buf_w = 0;

    // SRAM device: writes land at the clock edge while WE is low, reads are combinational
    always @(posedge clk) begin
        if (!bus.sram_ce_n && !bus.sram_we_n && bus.sram_dq_oe)
            mem[bus.sram_addr] <= bus.sram_dq_out;
    end

    assign bus.sram_dq_in = (!bus.sram_ce_n && !bus.sram_dq_oe) ? mem[bus.sram_addr] : 16'h0000;

    function automatic logic [15:0] init_half(input int h);
        logic [31:0] t;
        t = (h * 32'h9E37) ^ 32'h5A5A;
        return t[15:0];
    endfunction

    function automatic logic [15:0] ref_get(input int h);
        if (ref_half.exists(h)) return ref_half[h];
        return init_half(h);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        logic [31:0] na;
        na = (a >= 32'(BASE)) ? a - 32'(BASE) : a;
        return int'((na / 4) % (1 << (AW - 1)));
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        int w, frozen, ce_cyc, we_cyc, oe_err, rd_leak, first_addr, last_addr;
        bit got, hit;
        logic [31:0] exp_word, done_rdata;
        w          = word_of(a);
        hit        = HAS_BUF && rd && !wr && buf_valid && (buf_w == w);
        exp_word   = (rd && !wr) ? {ref_get(2 * w), ref_get(2 * w + 1)} : 32'h0;
        frozen     = 0;
        ce_cyc     = 0;
        we_cyc     = 0;
        oe_err     = 0;
        rd_leak    = 0;
        first_addr = -1;
        last_addr  = -1;
        got        = 1'b0;
        done_rdata = 32'h0;
        @(posedge clk);
        #1;
        bus.rd_en = rd;
        bus.wr_en = wr;
        bus.adr   = a;
        bus.wdata = d;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (!bus.sram_ce_n) begin
                if (ce_cyc == 0) first_addr = int'(bus.sram_addr);
                last_addr = int'(bus.sram_addr);
                ce_cyc++;
                if (!bus.sram_we_n) we_cyc++;
                if (bus.sram_dq_oe != wr) oe_err++;
            end
            if (bus.ready) begin
                done_rdata = bus.rdata;
                got = 1'b1;
                break;
            end
            if (bus.rdata != 32'h0) rd_leak++;
            frozen++;
        end
        @(posedge clk);
        #1;
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
        bus.adr   = $urandom;
        bus.wdata = $urandom;
        @(negedge clk);
        if (bus.rdata != 32'h0 || !bus.ready) rd_leak++;
        checkOutput("completed", 32'(got), 32'd1);
        checkOutput("frozen_cycles", frozen, hit ? 0 : 2 * W + 1);
        checkOutput("ce_cycles", ce_cyc, hit ? 0 : 2 * W);
        checkOutput("we_cycles", we_cyc, wr ? 2 * (W - 1) : 0);
        checkOutput("oe_errors", oe_err, 0);
        checkOutput("rdata_leak", rd_leak, 0);
        checkOutput("done_rdata", done_rdata, exp_word);
        if (!hit) begin
            checkOutput("hi_addr", first_addr, 2 * w);
            checkOutput("lo_addr", last_addr, 2 * w + 1);
        end
        if (wr) begin
            checkOutput("hi_half", {16'h0, mem[2 * w]}, {16'h0, d[31:16]});
            checkOutput("lo_half", {16'h0, mem[2 * w + 1]}, {16'h0, d[15:0]});
            ref_half[2 * w]     = d[31:16];
            ref_half[2 * w + 1] = d[15:0];
            buf_valid = 1'b0;
        end else if (rd && !hit) begin
            buf_valid = 1'b1;
            buf_w     = w;
        end
    endtask

    initial begin
        int          kind, sel;
        logic [31:0] a;
        bus.rd_en = 1'b0;
        bus.wr_en = 1'b0;
        bus.adr   = 32'h0;
        bus.wdata = 32'h0;
        for (int i = 0; i < NHALF; i++) mem[i] <= init_half(i);
        #1 rst = 1'b1;
        #2;
        checkOutput("rst_ready", 32'(bus.ready), 32'd1);
        checkOutput("rst_rdata", bus.rdata, 32'h0);
        checkOutput("rst_ce_n", 32'(bus.sram_ce_n), 32'd1);
        checkOutput("rst_we_n", 32'(bus.sram_we_n), 32'd1);
        checkOutput("rst_oe", 32'(bus.sram_dq_oe), 32'd0);
        checkOutput("rst_addr", 32'(bus.sram_addr), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        $display("[TB] directed scenarios");
        applyStimulus(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF);
        applyStimulus(1'b1, 1'b0, 32'd1028, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'd1028, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'd8, 32'h0);
        applyStimulus(1'b1, 1'b1, 32'd1032, 32'h12345678);
        applyStimulus(1'b1, 1'b0, 32'd1032, 32'h0);
        applyStimulus(1'b0, 1'b1, 32'd1028, 32'h0BADF00D);
        applyStimulus(1'b1, 1'b0, 32'd1028, 32'h0);

        $display("[TB] reset during PH1 of a write");
        @(posedge clk);
        #1;
        bus.wr_en = 1'b1;
        bus.adr   = 32'd1036;
        bus.wdata = 32'hCAFEF00D;
        @(negedge clk);
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("ph1_we_n", 32'(bus.sram_we_n), 32'd0);
        checkOutput("ph1_addr", 32'(bus.sram_addr), 32'd7);
        #1 rst = 1'b1;
        #1;
        checkOutput("midrst_we_n", 32'(bus.sram_we_n), 32'd1);
        checkOutput("midrst_ce_n", 32'(bus.sram_ce_n), 32'd1);
        checkOutput("midrst_oe", 32'(bus.sram_dq_oe), 32'd0);
        checkOutput("midrst_addr", 32'(bus.sram_addr), 32'd0);
        checkOutput("midrst_ready", 32'(bus.ready), 32'd0);
        bus.wr_en = 1'b0;
        #1;
        checkOutput("midrst_ready_idle", 32'(bus.ready), 32'd1);
        ref_half[6] = 16'hCAFE;
        buf_valid   = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(1'b1, 1'b0, 32'd1036, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'd1036, 32'h0);

        $display("[TB] random traffic");
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 9);
            sel  = $urandom_range(0, 3);
            case (sel)
                0:       a = 32'(BASE) + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
                1:       a = 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
                2:       a = 32'(BASE - 4) + 32'($urandom_range(0, 3));
                default: a = $urandom;
            endcase
            if (kind < 5)      applyStimulus(1'b1, 1'b0, a, $urandom);
            else if (kind < 8) applyStimulus(1'b0, 1'b1, a, $urandom);
            else               applyStimulus(1'b1, 1'b1, a, $urandom);
            if ($urandom_range(0, 1) == 1) @(posedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
